// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: access size codes,
// controller state encoding and the alignment rule.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Returns 1 when the access cannot be performed: halfword on an odd byte,
  // word off a 4-byte boundary, or the reserved size code.
  function automatic logic misaligned(input logic [1:0] addr_lo,
                                      input logic [1:0] size);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = addr_lo[0];
      SZ_W:    mis = |addr_lo;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the right-aligned core view and the 32-bit RAM
// word: byte enables and replicated store data on the way in, lane selection
// plus sign/zero extension on the way out.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] ldata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rword[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];

  // Decode lanes and extend the selected load value.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    be        = 4'b0000;
    wdata_rep = 32'h0;
    ldata     = 32'h0;
    case (size)
      SZ_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        ldata     = uns ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_H: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        ldata     = uns ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      SZ_W: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        ldata     = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: accepts one load/store per request handshake,
// optionally stalls for WAIT_CYCLES, then performs the byte-enabled access on
// the completion edge and presents a registered result with a done pulse.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 16384,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;   // access completes at the next edge
  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [AW+1:0] addr_q;
  logic [31:0] wdata_q;
  logic        done_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          accept;
  logic          mis;
  logic [AW-1:0] idx;
  logic [31:0]   rword;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic [31:0]   ldata;
  logic          unused_addr_hi;

  // Address bits above the RAM size are aliases and deliberately dropped.
  assign unused_addr_hi = ^addr[31:AW+2];

  assign ready  = (state_q == ST_IDLE);
  assign accept = req && ready;
  assign idx    = addr_q[AW+1:2];
  assign rword  = mem_q[idx];
  assign mis    = misaligned(addr_q[1:0], size_q);

  dmem_lane_align u_align (
    .addr_lo   (addr_q[1:0]),
    .size      (size_q),
    .uns       (uns_q),
    .wdata     (wdata_q),
    .rword     (rword),
    .be        (be),
    .wdata_rep (wdata_rep),
    .ldata     (ldata)
  );

  // Next-state logic for the busy counter and the completion strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            pend_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          pend_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state, request latch and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // here sees the pre-edge values, e.g. completion uses the old latch even
    // when a new request is captured on the same edge.
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      pend_q  <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      done_q  <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      if (accept) begin
        we_q    <= we;
        uns_q   <= uns;
        size_q  <= size;
        addr_q  <= addr[AW+1:0];
        wdata_q <= wdata;
      end
      done_q  <= pend_q;
      err_q   <= pend_q && mis;
      rdata_q <= (pend_q && !we_q && !mis) ? ldata : 32'h0;
    end
  end

  // Byte-enabled RAM write on the completion edge.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset; clearing it would defeat RAM
    // inference, and a store is cancelled by reset clearing pend_q instead.
    if (pend_q && we_q && !mis) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][b*8 +: 8] <= wdata_rep[b*8 +: 8];
      end
    end
  end

  assign done  = done_q;
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (large RAM / no wait states, 16-word RAM /
// three wait states), spec vectors from a table, hand sequences for handshake
// corners, and random traffic against a byte-addressed reference memory.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_v   [2];
  logic        req_v   [2];
  logic        we_v    [2];
  logic [31:0] addr_v  [2];
  logic [1:0]  size_v  [2];
  logic        uns_v   [2];
  logic [31:0] wdata_v [2];
  logic        ready_v [2];
  logic        done_v  [2];
  logic [31:0] rdata_v [2];
  logic        err_v   [2];

  int checks   = 0;
  int failures = 0;

  // Reference memories, one byte per entry, zero at start like the RAM.
  logic [7:0] ref_a [65536];
  logic [7:0] ref_b [64];

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH_WORDS(16384), .WAIT_CYCLES(0)) u_a (
    .clk(clk), .rst(rst_v[0]), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
    .size(size_v[0]), .uns(uns_v[0]), .wdata(wdata_v[0]), .ready(ready_v[0]),
    .done(done_v[0]), .rdata(rdata_v[0]), .err(err_v[0])
  );

  dmem_ctrl #(.DEPTH_WORDS(16), .WAIT_CYCLES(3)) u_b (
    .clk(clk), .rst(rst_v[1]), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
    .size(size_v[1]), .uns(uns_v[1]), .wdata(wdata_v[1]), .ready(ready_v[1]),
    .done(done_v[1]), .rdata(rdata_v[1]), .err(err_v[1])
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t tab [19];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic [7:0] ref_get(input int d, input logic [31:0] a);
    return (d == 0) ? ref_a[a % 65536] : ref_b[a % 64];
  endfunction

  task automatic ref_set(input int d, input logic [31:0] a, input logic [7:0] v);
    if (d == 0) ref_a[a % 65536] = v;
    else        ref_b[a % 64]    = v;
  endtask

  // Reference behaviour: little-endian byte memory, natural alignment rule.
  task automatic ref_access(input int d, input logic w, input logic [31:0] a,
                            input logic [1:0] sz, input logic u, input logic [31:0] wd,
                            output logic [31:0] data, output logic e);
    int nb;
    logic [31:0] v;
    nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
    e    = (nb == 0) || ((a % nb) != 0);
    data = 32'h0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < nb; i++) ref_set(d, a + 32'(i), wd[8*i +: 8]);
      end else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_get(d, a + 32'(i))) << (8*i));
        if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        data = v;
      end
    end
  endtask

  task automatic drive(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [1:0] sz, input logic u, input logic [31:0] wd);
    req_v[d]   = r;
    we_v[d]    = w;
    addr_v[d]  = a;
    size_v[d]  = sz;
    uns_v[d]   = u;
    wdata_v[d] = wd;
  endtask

  // One complete access: issue, check latency, result, and single-cycle done.
  task automatic do_access(input int d, input logic w, input logic [31:0] a,
                           input logic [1:0] sz, input logic u, input logic [31:0] wd,
                           input logic use_tab, input logic [31:0] t_rdata,
                           input logic t_err, input string nm);
    logic [31:0] exp_d;
    logic        exp_e;
    int          k;
    bit          seen;
    ref_access(d, w, a, sz, u, wd, exp_d, exp_e);
    if (use_tab) begin
      exp_d = t_rdata;
      exp_e = t_err;
    end
    for (int n = 0; n < 20 && !ready_v[d]; n++) @(negedge clk);
    check({nm, "_ready"}, 32'(ready_v[d]), 32'd1);
    drive(d, 1'b1, w, a, sz, u, wd);
    @(negedge clk);
    req_v[d] = 1'b0;
    seen = 0;
    k    = 0;
    for (int n = 0; n <= wait_of(d) + 4; n++) begin
      if (done_v[d]) begin
        seen = 1;
        k    = n;
        break;
      end
      @(negedge clk);
    end
    check({nm, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({nm, "_latency"}, 32'(k), 32'(wait_of(d) + 1));
      check({nm, "_rdata"}, rdata_v[d], exp_d);
      check({nm, "_err"}, 32'(err_v[d]), 32'(exp_e));
      @(negedge clk);
      check({nm, "_done_pulse"}, 32'(done_v[d]), 32'd0);
      check({nm, "_rdata_idle"}, rdata_v[d], 32'h0);
    end
  endtask

  initial begin
    logic [31:0] a, wd, ed;
    logic [1:0]  sz;
    logic        w, u, ee;
    int          dones;

    foreach (ref_a[i]) ref_a[i] = 8'h00;
    foreach (ref_b[i]) ref_b[i] = 8'h00;
    for (int d = 0; d < 2; d++) begin
      rst_v[d] = 1'b1;
      drive(d, 1'b0, 1'b0, 32'h0, SZ_W, 1'b0, 32'h0);
    end

    // Reset state, visible before any clock edge.
    #2;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst%0d_ready", d), 32'(ready_v[d]), 32'd1);
      check($sformatf("rst%0d_done", d),  32'(done_v[d]),  32'd0);
      check($sformatf("rst%0d_rdata", d), rdata_v[d],      32'h0);
      check($sformatf("rst%0d_err", d),   32'(err_v[d]),   32'd0);
    end
    repeat (2) @(negedge clk);
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;

    // ---------------- instance A: no wait states ----------------
    for (int i = 0; i < 64; i++) do_access(0, 1'b1, 32'(i*4), SZ_W, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "clr_a");

    tab[0]  = '{1'b1, 32'h10, SZ_W, 1'b0, 32'h1234_5678, 32'h0,         1'b0};
    tab[1]  = '{1'b0, 32'h10, SZ_W, 1'b0, 32'h0,         32'h1234_5678, 1'b0};
    tab[2]  = '{1'b1, 32'h11, SZ_B, 1'b0, 32'h9999_99AB, 32'h0,         1'b0};
    tab[3]  = '{1'b0, 32'h11, SZ_B, 1'b0, 32'h0,         32'hFFFF_FFAB, 1'b0};
    tab[4]  = '{1'b0, 32'h11, SZ_B, 1'b1, 32'h0,         32'h0000_00AB, 1'b0};
    tab[5]  = '{1'b0, 32'h10, SZ_W, 1'b0, 32'h0,         32'h1234_AB78, 1'b0};
    tab[6]  = '{1'b1, 32'h22, SZ_H, 1'b0, 32'h7777_8001, 32'h0,         1'b0};
    tab[7]  = '{1'b0, 32'h22, SZ_H, 1'b0, 32'h0,         32'hFFFF_8001, 1'b0};
    tab[8]  = '{1'b0, 32'h22, SZ_H, 1'b1, 32'h0,         32'h0000_8001, 1'b0};
    tab[9]  = '{1'b0, 32'h23, SZ_H, 1'b0, 32'h0,         32'h0,         1'b1};
    tab[10] = '{1'b1, 32'h21, SZ_H, 1'b0, 32'h0000_5555, 32'h0,         1'b1};
    tab[11] = '{1'b1, 32'h22, SZ_W, 1'b0, 32'h5555_5555, 32'h0,         1'b1};
    tab[12] = '{1'b1, 32'h20, 2'b11, 1'b0, 32'h5555_5555, 32'h0,        1'b1};
    tab[13] = '{1'b0, 32'h20, SZ_W, 1'b0, 32'h0,         32'h8001_0000, 1'b0};
    tab[14] = '{1'b0, 32'h20, 2'b11, 1'b0, 32'h0,        32'h0,         1'b1};
    tab[15] = '{1'b1, 32'h13, SZ_B, 1'b0, 32'h0000_007F, 32'h0,         1'b0};
    tab[16] = '{1'b0, 32'h13, SZ_B, 1'b0, 32'h0,         32'h0000_007F, 1'b0};
    tab[17] = '{1'b0, 32'h12, SZ_B, 1'b0, 32'h0,         32'h0000_0034, 1'b0};
    tab[18] = '{1'b0, 32'hABCD_0010, SZ_W, 1'b0, 32'h0,  32'h7F34_AB78, 1'b0};
    for (int i = 0; i < 19; i++)
      do_access(0, tab[i].we, tab[i].addr, tab[i].size, tab[i].uns, tab[i].wdata,
                1'b1, tab[i].rdata, tab[i].err, $sformatf("tab%0d", i));

    // Back-to-back store then load of the same word, one per cycle.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h30, SZ_W, 1'b0, 32'hA5A5_0F0F);
    ref_access(0, 1'b1, 32'h30, SZ_W, 1'b0, 32'hA5A5_0F0F, ed, ee);
    @(negedge clk);
    check("b2b_ready", 32'(ready_v[0]), 32'd1);
    drive(0, 1'b1, 1'b0, 32'h30, SZ_W, 1'b0, 32'h0);
    @(negedge clk);
    req_v[0] = 1'b0;
    check("b2b_st_done", 32'(done_v[0]), 32'd1);
    check("b2b_st_rdata", rdata_v[0], 32'h0);
    @(negedge clk);
    check("b2b_ld_done", 32'(done_v[0]), 32'd1);
    check("b2b_ld_rdata", rdata_v[0], 32'hA5A5_0F0F);
    check("b2b_ld_err", 32'(err_v[0]), 32'd0);
    @(negedge clk);
    check("b2b_idle", 32'(done_v[0]), 32'd0);

    // Random traffic; upper address bits vary to exercise aliasing.
    for (int i = 0; i < 200; i++) begin
      a       = $urandom;
      a[15:8] = 8'h00;
      sz      = 2'($urandom_range(0, 3));
      w       = 1'($urandom_range(0, 1));
      u       = 1'($urandom_range(0, 1));
      wd      = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == SZ_W) a[1:0] = 2'b00;
        if (sz == SZ_H) a[0]   = 1'b0;
      end
      do_access(0, w, a, sz, u, wd, 1'b0, 32'h0, 1'b0, "rnd_a");
    end

    // ---------------- instance B: 16 words, 3 wait states ----------------
    for (int i = 0; i < 16; i++) do_access(1, 1'b1, 32'(i*4), SZ_W, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "clr_b");
    do_access(1, 1'b1, 32'h40, SZ_W, 1'b0, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b0, "wrap_st");
    do_access(1, 1'b0, 32'h00, SZ_W, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, "wrap_ld");
    do_access(1, 1'b0, 32'h04, 2'b11, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, "size11");

    // Busy window: a request while ready is low must be dropped.
    @(negedge clk);
    ref_access(1, 1'b0, 32'h0, SZ_W, 1'b0, 32'h0, ed, ee);
    drive(1, 1'b1, 1'b0, 32'h0, SZ_W, 1'b0, 32'h0);
    @(negedge clk);
    check("busy_ready_c0", 32'(ready_v[1]), 32'd0);
    drive(1, 1'b1, 1'b1, 32'h4, SZ_W, 1'b0, 32'h1111_1111);
    @(negedge clk);
    check("busy_ready_c1", 32'(ready_v[1]), 32'd0);
    @(negedge clk);
    check("busy_ready_c2", 32'(ready_v[1]), 32'd0);
    req_v[1] = 1'b0;
    @(negedge clk);
    check("busy_ready_c3", 32'(ready_v[1]), 32'd1);
    check("busy_early_done", 32'(done_v[1]), 32'd0);
    @(negedge clk);
    check("busy_done", 32'(done_v[1]), 32'd1);
    check("busy_rdata", rdata_v[1], ed);
    dones = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done_v[1]) dones++;
    end
    check("busy_req_ignored", 32'(dones), 32'd0);
    do_access(1, 1'b0, 32'h4, SZ_W, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "busy_no_write");

    // Reset two cycles into a store: store is lost, outputs idle at once.
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 32'h8, SZ_W, 1'b0, 32'hDEAD_BEEF);
    @(negedge clk);
    req_v[1] = 1'b0;
    @(negedge clk);
    check("rstmid_busy", 32'(ready_v[1]), 32'd0);
    rst_v[1] = 1'b1;
    #1;
    check("rstmid_ready", 32'(ready_v[1]), 32'd1);
    check("rstmid_done", 32'(done_v[1]), 32'd0);
    check("rstmid_rdata", rdata_v[1], 32'h0);
    @(negedge clk);
    rst_v[1] = 1'b0;
    dones = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done_v[1]) dones++;
    end
    check("rstmid_no_done", 32'(dones), 32'd0);
    do_access(1, 1'b0, 32'h8, SZ_W, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, "rstmid_old");

    for (int i = 0; i < 60; i++) begin
      a  = $urandom;
      sz = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      wd = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == SZ_W) a[1:0] = 2'b00;
        if (sz == SZ_H) a[0]   = 1'b0;
      end
      do_access(1, w, a, sz, u, wd, 1'b0, 32'h0, 1'b0, "rnd_b");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
